// File: rtl/pix_stream_pkg.sv
// ============================================================
// pix_stream_pkg : shared FSM states, geometry defaults, clog2
// Revision: 1.0
// ============================================================
`default_nettype none

package pix_stream_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Geometry defaults, shared with lin_buff
  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_IMG_WIDTH   = 854;
  localparam int DEF_IMG_HEIGHT  = 480;
  localparam int DEF_ADDR_WIDTH  = 19;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pix_stream_src_if.sv
// ============================================================
// pix_stream_src_if : frame RAM read port plus pixel stream bundle
// Revision: 1.0
// ============================================================
`default_nettype none

interface pix_stream_src_if import pix_stream_pkg::*; #(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) ();

  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [PIXEL_WIDTH-1:0] mem_rd_data;
  logic                   p_valid;
  logic                   p_ready;
  logic [PIXEL_WIDTH-1:0] pixel;
  logic                   p_eol;
  logic                   p_eof;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output p_valid, pixel, p_eol, p_eof,
    input  p_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  p_valid, pixel, p_eol, p_eof,
    output p_ready
  );

endinterface

`default_nettype wire

// File: rtl/pix_skid_fifo.sv
// ============================================================
// pix_skid_fifo : 2-entry skid FIFO holding {eof, eol, pixel}
// Revision: 1.0
// ============================================================
`default_nettype none

module pix_skid_fifo import pix_stream_pkg::*; #(
  parameter int DATA_WIDTH = DEF_PIXEL_WIDTH + 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push,
  input  wire logic [DATA_WIDTH-1:0] push_data,
  input  wire logic                  pop,
  output logic      [DATA_WIDTH-1:0] head,
  output logic      [1:0]            count,
  output logic                       empty
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) r_wr_ptr <= ~r_wr_ptr;
      if (pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/pix_stream_src.sv
// ============================================================
// pix_stream_src : streams one frame from RAM in raster order
// Optional: PIX_SRC_FRAME_REPEAT_EN (continuous back-to-back frames)
// Revision: 1.0
// ============================================================
`default_nettype none

module pix_stream_src import pix_stream_pkg::*; #(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  output logic             busy,
  output logic             done,
  pix_stream_src_if.master bus
);

  localparam int c_col_w   = (clog2(IMG_WIDTH)  > 0) ? clog2(IMG_WIDTH)  : 1;
  localparam int c_row_w   = (clog2(IMG_HEIGHT) > 0) ? clog2(IMG_HEIGHT) : 1;
  localparam int c_entry_w = PIXEL_WIDTH + 2;
  localparam logic [c_col_w-1:0]    c_col_last  = c_col_w'(IMG_WIDTH - 1);
  localparam logic [c_row_w-1:0]    c_row_last  = c_row_w'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_last = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic                  r_done;
  logic [c_col_w-1:0]    r_col;
  logic [c_row_w-1:0]    r_row;

  logic [c_entry_w-1:0]  w_head;
  logic [c_entry_w-1:0]  w_out;
  logic [1:0]            w_count;
  logic                  w_empty;
  logic [2:0]            w_credit;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_pop;
  logic                  w_tag_eol;
  logic                  w_tag_eof;

  assign w_accept   = (r_state == IDLE) && start && !r_done;
  assign w_pop      = !w_empty && bus.p_ready;
  // Occupancy after this cycle's pop plus the read still in the RAM pipe
  assign w_credit   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == RUN) && (w_credit < 3'd2);
  assign w_last_pop = w_pop && w_head[c_entry_w-1];

  // Entries are tagged on entry, so the tag counters follow the push side
  assign w_tag_eol  = (r_col == c_col_last);
  assign w_tag_eof  = w_tag_eol && (r_row == c_row_last);

  pix_skid_fifo #(
    .DATA_WIDTH (c_entry_w)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data ({w_tag_eof, w_tag_eol, bus.mem_rd_data}),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_last_pop;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_addr  <= '0;
          end
        end
        RUN: begin
          if (w_issue) begin
            if (r_addr == c_addr_last) begin
`ifdef PIX_SRC_FRAME_REPEAT_EN
              r_addr  <= '0;
`else
              r_state <= DRAIN;
`endif
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (w_last_pop) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_inflight) begin
      if (w_tag_eol) begin
        r_col <= '0;
        r_row <= w_tag_eof ? '0 : r_row + c_row_w'(1);
      end else begin
        r_col <= r_col + c_col_w'(1);
      end
    end
  end

  // Stale entries stay in storage, so blank the outputs while empty
  assign w_out         = w_empty ? '0 : w_head;
  assign bus.p_valid   = !w_empty;
  assign bus.pixel     = w_out[PIXEL_WIDTH-1:0];
  assign bus.p_eol     = w_out[PIXEL_WIDTH];
  assign bus.p_eof     = w_out[PIXEL_WIDTH+1];
  assign bus.mem_rd_en = w_issue;
  assign bus.mem_addr  = r_addr;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pix_stream_src.sv
// ============================================================
// tb_pix_stream_src : scoreboard bench for pix_stream_src (4x3 image)
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_pix_stream_src;

  localparam int PW = 8;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NPIX = W * H;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  pix_stream_src_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  pix_stream_src #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame RAM with RAM[i] = i, one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= PW'(bus.mem_addr);
  end

  int checks = 0;
  int errors = 0;
  logic [PW+1:0] sb [$];
  logic          hold_v = 1'b0;
  logic [PW+1:0] hold_word = '0;
  logic          exp_done = 1'b0;
  logic          rand_ready = 1'b0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_hs = 0;
  int last_hs = 0;
  int n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frames(input int frames);
    logic [PW+1:0] e;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        e[PW-1:0] = PW'(i);
        e[PW]     = ((i % W) == W - 1);
        e[PW+1]   = (i == NPIX - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Output-side observer, run at the falling edge of every cycle
  task automatic monitor();
    logic [PW+1:0] word;
    logic [PW+1:0] exp;
    word = {bus.p_eof, bus.p_eol, bus.pixel};
    cyc++;
    if (rst) begin
      hold_v   = 1'b0;
      exp_done = 1'b0;
      return;
    end
    check("done_pulse", 32'(done), 32'(exp_done));
    exp_done = 1'b0;
    if (done) done_cnt++;
    if (bus.mem_rd_en) rd_cnt++;
    if (hold_v) begin
      check("hold_valid", 32'(bus.p_valid), 32'd1);
      check("hold_word", 32'(word), 32'(hold_word));
    end
    if (bus.p_valid && bus.p_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pixel observed=%0h expected=none", word);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("pixel_word", 32'(word), 32'(exp));
        exp_done = exp[PW+1];
      end
      hs_cnt++;
      if (hs_cnt == 1) first_hs = cyc;
      last_hs = cyc;
      hold_v = 1'b0;
    end else begin
      hold_v    = bus.p_valid;
      hold_word = word;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      if (rand_ready) bus.p_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
    check({tag, "_rd_en"},   32'(bus.mem_rd_en), 32'd0);
    check({tag, "_addr"},    32'(bus.mem_addr), 32'd0);
    check({tag, "_p_valid"}, 32'(bus.p_valid), 32'd0);
    check({tag, "_p_eol"},   32'(bus.p_eol), 32'd0);
    check({tag, "_p_eof"},   32'(bus.p_eof), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.p_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

`ifndef PIX_SRC_FRAME_REPEAT_EN
    // 1: full-rate frame, latency and done timing
    bus.p_ready = 1'b1;
    push_frames(1);
    pulse_start();
    check("t1_rd_en_n1", 32'(bus.mem_rd_en), 32'd1);
    check("t1_addr_n1", 32'(bus.mem_addr), 32'd0);
    check("t1_busy_n1", 32'(busy), 32'd1);
    check("t1_valid_n1", 32'(bus.p_valid), 32'd0);
    tick();
    check("t1_valid_n2", 32'(bus.p_valid), 32'd0);
    tick();
    check("t1_valid_n3", 32'(bus.p_valid), 32'd1);
    check("t1_pixel_n3", 32'(bus.pixel), 32'd0);
    wait_done(40, n);
    check("t1_cycles_to_done", 32'(n), 32'(NPIX));
    check("t1_busy_at_done", 32'(busy), 32'd0);
    tick();
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: random backpressure
    push_frames(1);
    hs_cnt = 0;
    rand_ready = 1'b1;
    pulse_start();
    wait_done(400, n);
    rand_ready = 1'b0;
    bus.p_ready = 1'b1;
    check("t2_handshakes", 32'(hs_cnt), 32'(NPIX));
    tick();
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: long stall after first valid
    bus.p_ready = 1'b0;
    push_frames(1);
    rd_cnt = 0;
    pulse_start();
    n = 0;
    while (bus.p_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("t3_first_valid", 32'(bus.p_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_no_read_stalled", 32'(bus.mem_rd_en), 32'd0);
    end
    check("t3_reads_outstanding", 32'(rd_cnt), 32'd2);
    check("t3_pixel_held", 32'(bus.pixel), 32'd0);
    bus.p_ready = 1'b1;
    wait_done(40, n);
    tick();
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: start re-pulsed mid-frame, and start coincident with done
    push_frames(1);
    done_cnt = 0;
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_done(40, n);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("t4_done_count", 32'(done_cnt), 32'd1);
    check("t4_busy_idle", 32'(busy), 32'd0);
    check("t4_valid_idle", 32'(bus.p_valid), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: reset while pixel 5 is presented
    push_frames(1);
    pulse_start();
    n = 0;
    while (!(bus.p_valid === 1'b1 && bus.pixel === PW'(5)) && n < 20) begin
      tick();
      n++;
    end
    check("t5_reached_pixel5", 32'(bus.pixel), 32'd5);
    #1 rst = 1'b1;
    #1 check_all_zero("t5_async_reset");
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    push_frames(1);
    pulse_start();
    wait_done(40, n);
    tick();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
`else
    // 6: continuous video, three back-to-back frames
    bus.p_ready = 1'b1;
    push_frames(3);
    hs_cnt   = 0;
    done_cnt = 0;
    pulse_start();
    n = 0;
    while (hs_cnt < 3 * NPIX && n < 100) begin
      tick();
      n++;
    end
    bus.p_ready = 1'b0;
    check("t6_handshakes", 32'(hs_cnt), 32'(3 * NPIX));
    check("t6_no_bubble", 32'(last_hs - first_hs), 32'(3 * NPIX - 1));
    check("t6_done_last", 32'(done), 32'd1);
    check("t6_busy_run", 32'(busy), 32'd1);
    tick();
    check("t6_done_count", 32'(done_cnt), 32'd3);
    check("t6_next_frame_valid", 32'(bus.p_valid), 32'd1);
    check("t6_busy_stays", 32'(busy), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    #1 rst = 1'b1;
    #1 check_all_zero("t6_reset");
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
